mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface for the multicycle MIPS core. It sits between the datapath (MEM stage of the control FSM) and the word-addressed RAM.
- Accepts one load/store request at a time and drives the RAM's Addr/R/W/W_data from registers. It captures R_data and performs byte/halfword extraction with sign or zero extension.
- Sub-word stores are done as read-modify-write.
- Alignment and address range are checked before any RAM access.

---
 rtl/mau_pkg.sv | 32 +++
 rtl/mau_lane.sv | 56 +++++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings for the data-memory access unit.
// Holds the transfer-size codes, the FSM state encoding and the
// alignment helper used by the request checks.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    FIN  = 2'b11
  } state_e;

  // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = lsb[0];
      SZ_WORD: mis = (lsb != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane: little-endian byte/half lane logic for the access unit.
// Merges store data into a word read from RAM and extracts/extends
// load data. Only present when MAU_SUBWORD_EN is defined; word-only
// builds carry no lane logic at all.
`ifdef MAU_SUBWORD_EN
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  output logic [31:0] st_word,
  output logic [31:0] ld_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, then build the merged store word and the extended load word.
  always_comb begin
    byte_s  = rd_word[{lane, 3'b000} +: 8];
    if (lane[1]) begin
      half_s = rd_word[31:16];
    end else begin
      half_s = rd_word[15:0];
    end
    st_word = rd_word;
    ld_word = rd_word;
    case (size)
      SZ_BYTE: begin
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
        ld_word = {{24{sext & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        if (lane[1]) begin
          st_word[31:16] = wdata[15:0];
        end else begin
          st_word[15:0] = wdata[15:0];
        end
        ld_word = {{16{sext & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        st_word = wdata;
        ld_word = rd_word;
      end
      default: begin
        st_word = rd_word;
        ld_word = rd_word;
      end
    endcase
  end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory interface of the
// multicycle MIPS core. One load/store at a time; RAM strobes, address
// and write data are driven from registers. Requests are checked for
// reserved size, alignment and range before any RAM access.
// Build option MAU_SUBWORD_EN: when defined, byte/half loads (with
// sign/zero extension) and read-modify-write sub-word stores are
// supported; when undefined, byte/half requests complete with err.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int DataDepth = 256
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sext,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DataWidth-1:0] rdata,
  output logic [AddrWidth-1:0] mem_Addr,
  output logic                 mem_R,
  output logic                 mem_W,
  output logic [DataWidth-1:0] mem_W_data,
  input  logic [DataWidth-1:0] mem_R_data
);

  localparam logic [AddrWidth-1:0] ADDR_LIMIT = AddrWidth'(DataDepth * 4);

  state_e               state_r;
  logic                 rsvd_s;
  logic                 misalign_s;
  logic                 range_s;
  logic                 chk_err_s;
  logic [AddrWidth-1:0] word_addr_s;

`ifdef MAU_SUBWORD_EN
  logic                 we_r;
  logic [1:0]           size_r;
  logic                 sext_r;
  logic [1:0]           lane_r;
  logic [DataWidth-1:0] wdata_r;
  logic [DataWidth-1:0] st_word_s;
  logic [DataWidth-1:0] ld_word_s;

  mau_lane u_lane (
    .rd_word (mem_R_data),
    .wdata   (wdata_r),
    .size    (size_r),
    .lane    (lane_r),
    .sext    (sext_r),
    .st_word (st_word_s),
    .ld_word (ld_word_s)
  );
`else
  // Sign-extension control has no consumer in a word-only build.
  logic sext_unused_s;
  assign sext_unused_s = sext;
`endif

  // Classify the incoming request: reserved size, misalignment, out-of-range.
  always_comb begin
`ifdef MAU_SUBWORD_EN
    rsvd_s = (size == SZ_RSVD);
`else
    rsvd_s = (size != SZ_WORD);
`endif
    misalign_s  = is_misaligned(size, addr[1:0]);
    range_s     = (addr >= ADDR_LIMIT);
    chk_err_s   = rsvd_s | misalign_s | range_s;
    word_addr_s = {addr[AddrWidth-1:2], 2'b00};
  end

  // Control FSM with registered RAM strobes, address, write data and results.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_R      <= 1'b0;
      mem_W      <= 1'b0;
      rdata      <= {DataWidth{1'b0}};
      mem_Addr   <= {AddrWidth{1'b0}};
      mem_W_data <= {DataWidth{1'b0}};
`ifdef MAU_SUBWORD_EN
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      sext_r     <= 1'b0;
      lane_r     <= 2'b00;
      wdata_r    <= {DataWidth{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          mem_R <= 1'b0;
          mem_W <= 1'b0;
          if (req) begin
            busy <= 1'b1;
`ifdef MAU_SUBWORD_EN
            we_r    <= we;
            size_r  <= size;
            sext_r  <= sext;
            lane_r  <= addr[1:0];
            wdata_r <= wdata;
`endif
            if (chk_err_s) begin
              // Rejected requests never touch the RAM.
              state_r <= FIN;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (we && (size == SZ_WORD)) begin
              state_r    <= WR;
              mem_W      <= 1'b1;
              mem_Addr   <= word_addr_s;
              mem_W_data <= wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state_r  <= RD;
              mem_R    <= 1'b1;
              mem_Addr <= word_addr_s;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RD: begin
          mem_R <= 1'b0;
`ifdef MAU_SUBWORD_EN
          if (we_r) begin
            state_r    <= WR;
            mem_W      <= 1'b1;
            mem_W_data <= st_word_s;
          end else begin
            state_r <= FIN;
            done    <= 1'b1;
            rdata   <= ld_word_s;
          end
`else
          state_r <= FIN;
          done    <= 1'b1;
          rdata   <= mem_R_data;
`endif
        end
        WR: begin
          mem_W   <= 1'b0;
          state_r <= FIN;
          done    <= 1'b1;
        end
        FIN: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          mem_R   <= 1'b0;
          mem_W   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit.
// Each request pushes its expected response; a negedge monitor pops it
// when done is seen and checks err, latency, strobes, write data, rdata.
// Expectations follow MAU_SUBWORD_EN so both builds are covered.
module tb_mem_access_unit;

`ifdef MAU_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;
  localparam logic [31:0] W10 = SW ? 32'hDE55BEEF : 32'hDEADBEEF;
  localparam logic [31:0] W14 = SW ? 32'h80017F44 : 32'h11223344;

  logic        CLK = 1'b0;
  logic        Reset, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_Addr, mem_W_data, mem_R_data;
  logic        busy, done, err, mem_R, mem_W;

  mem_access_unit dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_Addr(mem_Addr), .mem_R(mem_R), .mem_W(mem_W),
    .mem_W_data(mem_W_data), .mem_R_data(mem_R_data)
  );

  always #5 CLK = ~CLK;

  // Word-addressed RAM model with combinational read.
  logic [31:0] ram [0:255];
  assign mem_R_data = ram[mem_Addr[9:2]];
  always @(posedge CLK) if (mem_W) ram[mem_Addr[9:2]] <= mem_W_data;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    int          lat;
    int          rcnt;
    int          wcnt;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0, n_fail = 0, done_cnt = 0, issued = 0;
  logic [31:0] last_rd = 32'h0;
  int          rcnt_m = 0, wcnt_m = 0;
  logic        overlap_m = 1'b0;
  logic [31:0] waddr_m = 32'h0, wdata_m = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: accumulate strobes per transaction and score on done.
  always @(negedge CLK) begin
    if (Reset) begin
      rcnt_m = 0; wcnt_m = 0; overlap_m = 1'b0;
    end else begin
      if (mem_R) rcnt_m++;
      if (mem_W) begin wcnt_m++; waddr_m = mem_Addr; wdata_m = mem_W_data; end
      if (mem_R && mem_W) overlap_m = 1'b1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done with empty scoreboard at t=%0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("err", {31'b0, err}, {31'b0, mon_e.err});
          chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("rd_strobes", 32'(rcnt_m), 32'(mon_e.rcnt));
          chk("wr_strobes", 32'(wcnt_m), 32'(mon_e.wcnt));
          chk("r_w_overlap", {31'b0, overlap_m}, 32'h0);
          if (mon_e.is_load) chk("rdata", rdata, mon_e.rdata);
          if (mon_e.wcnt != 0) begin
            chk("wr_addr", waddr_m, mon_e.waddr);
            chk("wr_data", wdata_m, mon_e.wdata);
          end
        end
        rcnt_m = 0; wcnt_m = 0; overlap_m = 1'b0;
      end
    end
  end

  // Issue one request, push its expectation and wait (bounded) for done.
  task automatic op(input logic w_i, input logic [1:0] sz_i, input logic sx_i,
                    input logic [31:0] a_i, input logic [31:0] d_i,
                    input logic e_err, input logic [31:0] e_rd, input int e_lat,
                    input int e_rc, input int e_wc, input logic [31:0] e_wa,
                    input logic [31:0] e_wd);
    exp_t e;
    int   t;
    @(negedge CLK);
    t = 0;
    while (busy && t < 20) begin @(negedge CLK); t++; end
    e.err = e_err; e.is_load = !w_i; e.lat = e_lat; e.rcnt = e_rc; e.wcnt = e_wc;
    e.waddr = e_wa; e.wdata = e_wd; e.rdata = last_rd;
    if (!w_i && !e_err) begin e.rdata = e_rd; last_rd = e_rd; end
    e.acc = cyc;
    exp_q.push_back(e);
    issued++;
    we = w_i; size = sz_i; sext = sx_i; addr = a_i; wdata = d_i; req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    t = 0;
    while (done_cnt < issued && t < 20) begin @(posedge CLK); t++; end
    if (done_cnt < issued) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: addr %h got no done after %0d cycles", a_i, t);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    Reset = 1'b1; req = 1'b0; we = 1'b0; size = W; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_mem_R", {31'b0, mem_R}, 32'h0);
    chk("rst_mem_W", {31'b0, mem_W}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_Addr", mem_Addr, 32'h0);
    chk("rst_mem_W_data", mem_W_data, 32'h0);
    Reset = 1'b0;

    // we size sext addr wdata | err rdata lat rcnt wcnt waddr wdata
    op(1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'h10, 32'hDEADBEEF);
    op(1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0, 32'h0);
    op(1'b1, B, 1'b0, 32'h12, 32'h00000055, !SW, 32'h0, SW ? 3 : 1, SW ? 1 : 0, SW ? 1 : 0,
       32'h10, 32'hDE55BEEF);
    op(1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, W10, 2, 1, 0, 32'h0, 32'h0);
    op(1'b0, B, 1'b1, 32'h11, 32'h0, !SW, 32'hFFFFFFBE, SW ? 2 : 1, SW ? 1 : 0, 0, 32'h0, 32'h0);
    op(1'b0, B, 1'b0, 32'h11, 32'h0, !SW, 32'h000000BE, SW ? 2 : 1, SW ? 1 : 0, 0, 32'h0, 32'h0);
    op(1'b0, H, 1'b1, 32'h12, 32'h0, !SW, 32'hFFFFDE55, SW ? 2 : 1, SW ? 1 : 0, 0, 32'h0, 32'h0);
    op(1'b0, H, 1'b0, 32'h10, 32'h0, !SW, 32'h0000BEEF, SW ? 2 : 1, SW ? 1 : 0, 0, 32'h0, 32'h0);
    // Error cases: misaligned word, out of range, reserved size, misaligned half, store out of range.
    op(1'b0, W, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    op(1'b0, W, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    op(1'b0, R, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    op(1'b0, H, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    op(1'b1, B, 1'b0, 32'h400, 32'h77, 1'b1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    // Half and byte read-modify-write on a second word.
    op(1'b1, W, 1'b0, 32'h14, 32'h11223344, 1'b0, 32'h0, 2, 0, 1, 32'h14, 32'h11223344);
    op(1'b1, H, 1'b0, 32'h16, 32'hFFFF8001, !SW, 32'h0, SW ? 3 : 1, SW ? 1 : 0, SW ? 1 : 0,
       32'h14, 32'h80013344);
    op(1'b1, B, 1'b0, 32'h15, 32'hABCDEF7F, !SW, 32'h0, SW ? 3 : 1, SW ? 1 : 0, SW ? 1 : 0,
       32'h14, 32'h80017F44);
    op(1'b0, W, 1'b0, 32'h14, 32'h0, 1'b0, W14, 2, 1, 0, 32'h0, 32'h0);
    // Top of the address range.
    op(1'b1, W, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0, 2, 0, 1, 32'h3FC, 32'hCAFEF00D);
    op(1'b0, W, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1, 0, 32'h0, 32'h0);
    op(1'b0, B, 1'b1, 32'h3FF, 32'h0, !SW, 32'hFFFFFFCA, SW ? 2 : 1, SW ? 1 : 0, 0, 32'h0, 32'h0);

    // Request pulsed while busy must be ignored: exactly one done.
    @(negedge CLK);
    last_rd = W10;
    mon_e.err = 1'b0;
    begin
      exp_t e;
      e.err = 1'b0; e.is_load = 1'b1; e.rdata = W10; e.lat = 2; e.rcnt = 1; e.wcnt = 0;
      e.waddr = 32'h0; e.wdata = 32'h0; e.acc = cyc;
      exp_q.push_back(e);
      issued++;
    end
    we = 1'b0; size = W; sext = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK); addr = 32'h14; req = 1'b1;
    @(negedge CLK);
    @(negedge CLK); req = 1'b0;
    repeat (6) @(posedge CLK);
    chk("busy_req_ignored_done_count", 32'(done_cnt), 32'(issued));

    // Reset during WR: strobe drops next cycle, no done.
    @(negedge CLK);
    we = 1'b1; size = W; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK);
    chk("wr_strobe_before_reset", {31'b0, mem_W}, 32'h1);
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("reset_mem_W_drop", {31'b0, mem_W}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    Reset = 1'b0;
    last_rd = 32'h0;
    repeat (5) @(posedge CLK);
    chk("reset_no_done", 32'(done_cnt), 32'(issued));

    // Recovery after reset.
    op(1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, W10, 2, 1, 0, 32'h0, 32'h0);

    repeat (3) @(posedge CLK);
    chk("final_done_count", 32'(done_cnt), 32'(issued));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
